nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller: steps phase_inc from start to stop (inclusive),
// holding each value for a programmable dwell, with single-shot or repeating sweeps.
//
// state | meaning
// IDLE  | waiting for a configuration; cfg_ready high
// PRIME | one cycle with nco_rst high; loads the dwell counter
// DWELL | holding phase_inc; stepping on dwell-counter terminal count
module nco_sweep_ctrl #(
    parameter int PHASE_ACC_BITS = 24,
    parameter int DWELL_BITS     = 16,
    parameter int CNT_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [PHASE_ACC_BITS-2:0] cfg_start_inc,
    input  logic [PHASE_ACC_BITS-2:0] cfg_stop_inc,
    input  logic [PHASE_ACC_BITS-2:0] cfg_step,
    input  logic [DWELL_BITS-1:0]     cfg_dwell,
    input  logic                      cfg_repeat,
    input  logic                      abort,
    output logic [PHASE_ACC_BITS-2:0] phase_inc,
    output logic                      nco_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [CNT_BITS-1:0]       sweep_cnt
);

    localparam int IW = PHASE_ACC_BITS - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;

    localparam logic [DWELL_BITS-1:0] DW_ONE  = DWELL_BITS'(1);
    localparam logic [CNT_BITS-1:0]   CNT_ONE = CNT_BITS'(1);

    logic [1:0]            state;
    logic [IW-1:0]         start_r;
    logic [IW-1:0]         stop_r;
    logic [IW-1:0]         step_r;
    logic [DWELL_BITS-1:0] dwell_r;
    logic                  repeat_r;
    logic [DWELL_BITS-1:0] dwell_cnt;

    logic [DWELL_BITS-1:0] dwell_reload;
    logic [IW:0]           next_sum;
    logic [IW-1:0]         next_inc;

    // A dwell of zero behaves as a dwell of one.
    assign dwell_reload = (dwell_r == '0) ? '0 : (dwell_r - DW_ONE);

    // One extra bit keeps the carry so an overflowing step still clamps to stop.
    assign next_sum = {1'b0, phase_inc} + {1'b0, step_r};
    assign next_inc = (next_sum > {1'b0, stop_r}) ? stop_r : next_sum[IW-1:0];

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            start_r   <= '0;
            stop_r    <= '0;
            step_r    <= '0;
            dwell_r   <= '0;
            repeat_r  <= 1'b0;
            dwell_cnt <= '0;
            phase_inc <= '0;
            nco_rst   <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        start_r   <= cfg_start_inc;
                        stop_r    <= cfg_stop_inc;
                        step_r    <= cfg_step;
                        dwell_r   <= cfg_dwell;
                        repeat_r  <= cfg_repeat;
                        phase_inc <= cfg_start_inc;
                        nco_rst   <= 1'b1;
                        sweep_cnt <= '0;
                        state     <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (abort) begin
                        phase_inc <= '0;
                        nco_rst   <= 1'b0;
                        aborted   <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        nco_rst   <= 1'b0;
                        dwell_cnt <= dwell_reload;
                        state     <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    // Abort takes priority over a coincident completion.
                    if (abort) begin
                        phase_inc <= '0;
                        nco_rst   <= 1'b0;
                        aborted   <= 1'b1;
                        state     <= S_IDLE;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW_ONE;
                    end else if ((phase_inc < stop_r) && (step_r != '0)) begin
                        phase_inc <= next_inc;
                        dwell_cnt <= dwell_reload;
                    end else begin
                        sweep_cnt <= sweep_cnt + CNT_ONE;
                        if (repeat_r) begin
                            phase_inc <= start_r;
                            dwell_cnt <= dwell_reload;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: expected phase_inc sequences are queued at
// configuration time and popped once per dwell cycle as the controller steps.
module tb_nco_sweep_ctrl;

    localparam int IW = 23;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [IW-1:0] cfg_start_inc;
    logic [IW-1:0] cfg_stop_inc;
    logic [IW-1:0] cfg_step;
    logic [15:0]   cfg_dwell;
    logic          cfg_repeat;
    logic          abort;
    logic [IW-1:0] phase_inc;
    logic          nco_rst;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [15:0]   sweep_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] last_val;

    nco_sweep_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start_inc(cfg_start_inc),
        .cfg_stop_inc (cfg_stop_inc),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_repeat   (cfg_repeat),
        .abort        (abort),
        .phase_inc    (phase_inc),
        .nco_rst      (nco_rst),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .sweep_cnt    (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference sequence of phase_inc values, one entry per dwell cycle.
    task automatic build_expected(input logic [IW-1:0] st, input logic [IW-1:0] sp,
                                  input logic [IW-1:0] stp, input logic [15:0] dw,
                                  input int nsw);
        logic [IW-1:0] v;
        logic [IW:0]   n;
        int            hold;
        hold = (dw == 16'd0) ? 1 : int'(dw);
        for (int s = 0; s < nsw; s++) begin
            v = st;
            forever begin
                for (int d = 0; d < hold; d++) exp_q.push_back(v);
                if ((v < sp) && (stp != '0)) begin
                    n = {1'b0, v} + {1'b0, stp};
                    v = (n > {1'b0, sp}) ? sp : n[IW-1:0];
                end else begin
                    break;
                end
            end
        end
    endtask

    task automatic sweep_run(input logic [IW-1:0] st, input logic [IW-1:0] sp,
                             input logic [IW-1:0] stp, input logic [15:0] dw,
                             input logic rep, input int nsw, input logic abort_idle,
                             input string tag, output logic [IW-1:0] last);
        int n;
        int bad;
        exp_q.delete();
        build_expected(st, sp, stp, dw, nsw);
        last = exp_q[exp_q.size()-1];
        @(negedge clk);
        chk(64'(cfg_ready), 64'd1, {tag, "_ready"});
        cfg_start_inc = st;
        cfg_stop_inc  = sp;
        cfg_step      = stp;
        cfg_dwell     = dw;
        cfg_repeat    = rep;
        cfg_valid     = 1'b1;
        abort         = abort_idle;
        @(negedge clk);
        cfg_valid = 1'b0;
        abort     = 1'b0;
        chk(64'(nco_rst), 64'd1, {tag, "_nco_rst_prime"});
        chk(64'(aborted), 64'd0, {tag, "_aborted_prime"});
        chk(64'(sweep_cnt), 64'd0, {tag, "_cnt_cleared"});
        chk(64'(phase_inc), 64'(st), {tag, "_inc_prime"});
        n   = exp_q.size();
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (nco_rst || !busy || done) bad++;
            chk(64'(phase_inc), 64'(exp_q.pop_front()), {tag, "_phase_seq"});
        end
        chk(64'(bad), 64'd0, {tag, "_dwell_state"});
    endtask

    task automatic finish_check(input logic [IW-1:0] last, input string tag);
        @(negedge clk);
        chk(64'(done), 64'd1, {tag, "_done"});
        chk(64'(busy), 64'd0, {tag, "_idle"});
        chk(64'(phase_inc), 64'(last), {tag, "_hold"});
        chk(64'(sweep_cnt), 64'd1, {tag, "_cnt"});
        @(negedge clk);
        chk(64'(done), 64'd0, {tag, "_done_pulse"});
        chk(64'(cfg_ready), 64'd1, {tag, "_ready_after"});
    endtask

    initial begin
        rst           = 1'b0;
        cfg_valid     = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_repeat    = 1'b0;
        abort         = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk(64'(phase_inc), 64'd0, "rst_phase");
        chk(64'(busy), 64'd0, "rst_busy");
        chk(64'(cfg_ready), 64'd1, "rst_ready");
        chk(64'(sweep_cnt), 64'd0, "rst_cnt");
        chk(64'({nco_rst, done, aborted}), 64'd0, "rst_pulses");

        // Basic linear sweep.
        sweep_run(23'd100, 23'd130, 23'd10, 16'd3, 1'b0, 1, 1'b0, "lin", last_val);
        finish_check(last_val, "lin");

        // Clamp to stop; abort asserted with the accept in IDLE is ignored.
        sweep_run(23'd100, 23'd125, 23'd10, 16'd2, 1'b0, 1, 1'b1, "clamp", last_val);
        finish_check(last_val, "clamp");

        // start > stop with zero dwell, then zero step.
        sweep_run(23'd50, 23'd40, 23'd5, 16'd0, 1'b0, 1, 1'b0, "rev", last_val);
        finish_check(last_val, "rev");
        sweep_run(23'd50, 23'd80, 23'd0, 16'd4, 1'b0, 1, 1'b0, "step0", last_val);
        finish_check(last_val, "step0");

        // Carry out of the increment width clamps to stop.
        sweep_run(23'h7FFFF0, 23'h7FFFFE, 23'h7FFFFF, 16'd1, 1'b0, 1, 1'b0, "carry", last_val);
        finish_check(last_val, "carry");

        // Repeating sweep, ignored reconfiguration, then abort.
        sweep_run(23'd0, 23'd20, 23'd10, 16'd1, 1'b1, 3, 1'b0, "rep", last_val);
        chk(64'(sweep_cnt), 64'd2, "rep_cnt2");
        cfg_start_inc = 23'd77;
        cfg_valid     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk(64'(phase_inc), 64'd0, "rep_wrap");
        chk(64'(sweep_cnt), 64'd3, "rep_cnt3");
        chk(64'({done, nco_rst}), 64'd0, "rep_no_done");
        @(negedge clk);
        chk(64'(phase_inc), 64'd10, "rep_cfg_ignored");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk(64'(aborted), 64'd1, "rep_aborted");
        chk(64'(busy), 64'd0, "rep_abort_idle");
        chk(64'(phase_inc), 64'd0, "rep_abort_inc");
        chk(64'(sweep_cnt), 64'd3, "rep_abort_cnt");
        chk(64'(done), 64'd0, "rep_abort_done");
        @(negedge clk);
        chk(64'(aborted), 64'd0, "rep_aborted_pulse");

        // Abort coinciding with the final dwell expiry.
        sweep_run(23'd100, 23'd130, 23'd10, 16'd3, 1'b0, 1, 1'b0, "abtend", last_val);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk(64'(aborted), 64'd1, "abtend_aborted");
        chk(64'(done), 64'd0, "abtend_done");
        chk(64'(sweep_cnt), 64'd0, "abtend_cnt");
        chk(64'(phase_inc), 64'd0, "abtend_inc");
        chk(64'(busy), 64'd0, "abtend_idle");

        // Asynchronous reset in the middle of a dwell.
        @(negedge clk);
        cfg_start_inc = 23'd300;
        cfg_stop_inc  = 23'd400;
        cfg_step      = 23'd25;
        cfg_dwell     = 16'd4;
        cfg_repeat    = 1'b1;
        cfg_valid     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk(64'(busy), 64'd1, "arst_pre_busy");
        #2 rst = 1'b0;
        #1;
        chk(64'(phase_inc), 64'd0, "arst_phase");
        chk(64'(busy), 64'd0, "arst_busy");
        chk(64'({nco_rst, done, aborted}), 64'd0, "arst_pulses");
        chk(64'(sweep_cnt), 64'd0, "arst_cnt");
        @(negedge clk);
        rst = 1'b1;
        sweep_run(23'd7, 23'd9, 23'd1, 16'd2, 1'b0, 1, 1'b0, "post", last_val);
        finish_check(last_val, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
